// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer and the ALU it drives:
// op codes, flag bit positions and the sequencer state encoding.
package alu_sequencer_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 3;

    // Flag vector is {carry/borrow, signed overflow, zero}
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Z = 0;

    localparam logic [OP_W-1:0] OP_ADD        = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB        = 4'd1;
    localparam logic [OP_W-1:0] OP_ADDS       = 4'd2;
    localparam logic [OP_W-1:0] OP_SUBS       = 4'd3;
    localparam logic [OP_W-1:0] OP_AND        = 4'd4;
    localparam logic [OP_W-1:0] OP_OR         = 4'd5;
    localparam logic [OP_W-1:0] OP_XOR        = 4'd6;
    localparam logic [OP_W-1:0] OP_NOR        = 4'd7;
    localparam logic [OP_W-1:0] OP_SLT        = 4'd8;
    localparam logic [OP_W-1:0] OP_LAST_LEGAL = OP_SLT;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_LAST_LEGAL);
    endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// Combinational ALU driven by alu_sequencer. Unsigned ops report carry/borrow,
// signed ops report overflow; illegal op codes produce zero with the zero flag.
module alu_sequencer_alu
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned MSB = 32
) (
    input  logic [MSB-1:0]    i_in1,
    input  logic [MSB-1:0]    i_in2,
    input  logic [OP_W-1:0]   i_s,
    output logic [MSB-1:0]    o_out_c,
    output logic [FLAG_W-1:0] o_f_c
);

    logic [MSB:0] w_sum;
    logic [MSB:0] w_dif;
    logic         w_add_v;
    logic         w_sub_v;
    alu_flags_t   w_flags;

    assign w_sum   = {1'b0, i_in1} + {1'b0, i_in2};
    assign w_dif   = {1'b0, i_in1} - {1'b0, i_in2};
    assign w_add_v = (i_in1[MSB-1] == i_in2[MSB-1]) && (w_sum[MSB-1] != i_in1[MSB-1]);
    assign w_sub_v = (i_in1[MSB-1] != i_in2[MSB-1]) && (w_dif[MSB-1] != i_in1[MSB-1]);

    always_comb begin
        o_out_c = '0;
        w_flags = '0;
        case (i_s)
            OP_ADD:  begin o_out_c = w_sum[MSB-1:0]; w_flags.c = w_sum[MSB]; end
            OP_SUB:  begin o_out_c = w_dif[MSB-1:0]; w_flags.c = w_dif[MSB]; end
            OP_ADDS: begin o_out_c = w_sum[MSB-1:0]; w_flags.v = w_add_v;    end
            OP_SUBS: begin o_out_c = w_dif[MSB-1:0]; w_flags.v = w_sub_v;    end
            OP_AND:  o_out_c = i_in1 & i_in2;
            OP_OR:   o_out_c = i_in1 | i_in2;
            OP_XOR:  o_out_c = i_in1 ^ i_in2;
            OP_NOR:  o_out_c = ~(i_in1 | i_in2);
            OP_SLT:  o_out_c = MSB'($signed(i_in1) < $signed(i_in2));
            default: o_out_c = '0;
        endcase
        w_flags.z = (o_out_c == '0);
        o_f_c     = w_flags;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Command/response sequencer for an external ALU: latches a command, captures
// the ALU result one cycle later and holds it until consumed. Keeps an
// accumulator and sticky flags.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned MSB = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [MSB-1:0]    cmd_a,
    input  logic [MSB-1:0]    cmd_b,
    input  logic              cmd_acc,
    output logic [MSB-1:0]    alu_in1,
    output logic [MSB-1:0]    alu_in2,
    output logic [OP_W-1:0]   alu_s,
    input  logic [MSB-1:0]    alu_out,
    input  logic [FLAG_W-1:0] alu_f,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [MSB-1:0]    rsp_data,
    output logic [FLAG_W-1:0] rsp_f,
    output logic              rsp_err,
    output logic [FLAG_W-1:0] sticky_f,
    input  logic              flag_clr,
    output logic [MSB-1:0]    acc_q,
    input  logic              acc_clr
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic              w_cmd_fire;
    logic              w_capture;
    logic              w_acc_wr;

    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [MSB-1:0]    r_rsp_data;
    logic [FLAG_W-1:0] r_rsp_f;
    logic              r_rsp_err;
    logic [FLAG_W-1:0] r_sticky_f;
    logic [MSB-1:0]    r_acc;
    logic              r_acc_sel;
    logic [MSB-1:0]    r_alu_in1;
    logic [MSB-1:0]    r_alu_in2;
    logic [OP_W-1:0]   r_alu_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_fire  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: if (cmd_valid && r_cmd_ready) begin
                w_cmd_fire  = 1'b1;
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: if (r_rsp_valid && rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_acc_wr = w_capture && r_acc_sel && op_is_legal(r_alu_s);

    // rsp_valid trails entry into RESP by one cycle and drops on the consuming edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= (r_state == ST_RESP) && (w_state_nxt == ST_RESP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_in1  <= '0;
            r_alu_in2  <= '0;
            r_alu_s    <= '0;
            r_acc_sel  <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_f    <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_cmd_fire) begin
                r_alu_in1 <= cmd_acc ? r_acc : cmd_a;
                r_alu_in2 <= cmd_b;
                r_alu_s   <= cmd_op;
                r_acc_sel <= cmd_acc;
            end
            if (w_capture) begin
                r_rsp_data <= alu_out;
                r_rsp_f    <= alu_f;
                r_rsp_err  <= !op_is_legal(r_alu_s);
            end
        end
    end

    // A capture takes priority over a coincident clear request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky_f <= '0;
            r_acc      <= '0;
        end else begin
            if (w_capture)     r_sticky_f <= (flag_clr ? '0 : r_sticky_f) | alu_f;
            else if (flag_clr) r_sticky_f <= '0;

            if (w_acc_wr)     r_acc <= alu_out;
            else if (acc_clr) r_acc <= '0;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_f     = r_rsp_f;
    assign rsp_err   = r_rsp_err;
    assign sticky_f  = r_sticky_f;
    assign acc_q     = r_acc;
    assign alu_in1   = r_alu_in1;
    assign alu_in2   = r_alu_in2;
    assign alu_s     = r_alu_s;

endmodule
